// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: two-input round-robin arbiter feeding a registered 2:1 mux
// output (Y, S) over valid/ready, with per-channel grant counters.
module mux2_rr_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             I0_valid,
    input  logic [WIDTH-1:0] I0_data,
    output logic             I0_ready,
    input  logic             I1_valid,
    input  logic [WIDTH-1:0] I1_data,
    output logic             I1_ready,
    output logic             Y_valid,
    output logic [WIDTH-1:0] Y,
    output logic             S,
    input  logic             Y_ready,
    output logic [CNT_W-1:0] grant0_cnt,
    output logic [CNT_W-1:0] grant1_cnt
);
    logic last, load, any, gnt;
    assign load = !Y_valid || Y_ready;
    assign any  = I0_valid || I1_valid;
    // on a tie the channel that did not win last time goes first
    assign gnt  = (I0_valid && I1_valid) ? ~last : I1_valid;
    assign I0_ready = !rst && load && any && !gnt;
    assign I1_ready = !rst && load && any && gnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y_valid    <= 1'b0;
            Y          <= '0;
            S          <= 1'b0;
            last       <= 1'b1;
            grant0_cnt <= '0;
            grant1_cnt <= '0;
        end else if (load) begin
            Y_valid <= any;
            if (any) begin
                Y    <= gnt ? I1_data : I0_data;
                S    <= gnt;
                last <= gnt;
                if (gnt) grant1_cnt <= grant1_cnt + CNT_W'(1);
                else     grant0_cnt <= grant0_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter: directed vector table plus hand-written sequences for
// async reset and 4-bit counter wrap.
module tb_mux2_rr_arbiter;
    localparam int W = 8, CW = 4, NV = 16;
    logic clk = 1'b0, rst = 1'b1;
    logic i0v = 1'b0, i1v = 1'b0, yr = 1'b0;
    logic [W-1:0] i0d = '0, i1d = '0;
    logic i0r, i1r, yv, s;
    logic [W-1:0] y;
    logic [CW-1:0] c0, c1;
    int n = 0, fails = 0;

    typedef struct {
        logic i0v; logic [7:0] i0d; logic i1v; logic [7:0] i1d; logic yr;
        logic [1:0] rdy; logic yv; logic [7:0] y; logic s; logic [3:0] c0; logic [3:0] c1;
    } vec_t;
    vec_t v [NV];

    mux2_rr_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .I0_valid(i0v), .I0_data(i0d), .I0_ready(i0r),
        .I1_valid(i1v), .I1_data(i1d), .I1_ready(i1r),
        .Y_valid(yv), .Y(y), .S(s), .Y_ready(yr),
        .grant0_cnt(c0), .grant1_cnt(c1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {14'd0, yv, y, s, c0, c1};
    endfunction

    function automatic logic [31:0] pk(input logic ev, input logic [7:0] ey, input logic es,
                                       input logic [3:0] e0, input logic [3:0] e1);
        return {14'd0, ev, ey, es, e0, e1};
    endfunction

    task automatic drive(input logic a, input logic [7:0] ad, input logic b, input logic [7:0] bd, input logic r);
        i0v = a; i0d = ad; i1v = b; i1d = bd; yr = r;
    endtask

    initial begin
        v[0]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 2'b01, 1'b1, 8'h11, 1'b0, 4'd1, 4'd0};
        v[1]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 2'b10, 1'b1, 8'h22, 1'b1, 4'd1, 4'd1};
        v[2]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 2'b01, 1'b1, 8'h11, 1'b0, 4'd2, 4'd1};
        v[3]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 2'b10, 1'b1, 8'h22, 1'b1, 4'd2, 4'd2};
        v[4]  = '{1'b0, 8'h00, 1'b1, 8'hA0, 1'b1, 2'b10, 1'b1, 8'hA0, 1'b1, 4'd2, 4'd3};
        v[5]  = '{1'b0, 8'h00, 1'b1, 8'hA1, 1'b1, 2'b10, 1'b1, 8'hA1, 1'b1, 4'd2, 4'd4};
        v[6]  = '{1'b0, 8'h00, 1'b1, 8'hA2, 1'b1, 2'b10, 1'b1, 8'hA2, 1'b1, 4'd2, 4'd5};
        v[7]  = '{1'b1, 8'h33, 1'b1, 8'hA3, 1'b1, 2'b01, 1'b1, 8'h33, 1'b0, 4'd3, 4'd5};
        for (int k = 8; k < 13; k++)
            v[k] = '{1'b1, 8'h44, 1'b1, 8'h55, 1'b0, 2'b00, 1'b1, 8'h33, 1'b0, 4'd3, 4'd5};
        v[13] = '{1'b1, 8'h44, 1'b1, 8'h55, 1'b1, 2'b10, 1'b1, 8'h55, 1'b1, 4'd3, 4'd6};
        v[14] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 2'b00, 1'b0, 8'h55, 1'b1, 4'd3, 4'd6};
        v[15] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 8'h55, 1'b1, 4'd3, 4'd6};

        repeat (2) @(negedge clk);
        chk("reset_state", outs(), pk(1'b0, 8'h00, 1'b0, 4'd0, 4'd0));
        chk("reset_ready", {30'd0, i1r, i0r}, 32'd0);
        rst = 1'b0;

        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            drive(v[k].i0v, v[k].i0d, v[k].i1v, v[k].i1d, v[k].yr);
            #1 chk($sformatf("vec%0d_ready", k), {30'd0, i1r, i0r}, {30'd0, v[k].rdy});
            @(posedge clk);
            #1 chk($sformatf("vec%0d_out", k), outs(), pk(v[k].yv, v[k].y, v[k].s, v[k].c0, v[k].c1));
        end

        // load a word, then reset asynchronously between edges
        @(negedge clk);
        drive(1'b1, 8'h66, 1'b1, 8'h77, 1'b1);
        @(posedge clk);
        #1 chk("pre_reset_out", outs(), pk(1'b1, 8'h66, 1'b0, 4'd4, 4'd6));
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("async_reset_out", outs(), pk(1'b0, 8'h00, 1'b0, 4'd0, 4'd0));
        chk("async_reset_ready", {30'd0, i1r, i0r}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_reset_tie_ready", {30'd0, i1r, i0r}, 32'd1);
        @(posedge clk);
        #1 chk("post_reset_tie_out", outs(), pk(1'b1, 8'h66, 1'b0, 4'd1, 4'd0));

        // 16 more channel-0 grants: 17 in total wraps the 4-bit counter to 1
        for (int k = 2; k <= 17; k++) begin
            @(negedge clk);
            drive(1'b1, 8'(k), 1'b0, 8'h00, 1'b1);
            @(posedge clk);
            #1 chk($sformatf("wrap%0d", k), outs(), pk(1'b1, 8'(k), 1'b0, 4'(k % 16), 4'd0));
        end
        chk("wrap_final_cnt0", {28'd0, c0}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n, fails);
        $finish;
    end
endmodule
